// File: rtl/vec_pipe_pkg.sv
// vec_pipe_pkg: shared lane/vector types, skid-buffer state encoding and occupancy width.
package vec_pipe_pkg;
    localparam int OCC_W = 2;
    localparam int DEF_REG_W = 16;
    localparam int DEF_VEC_N = 4;
    typedef logic [DEF_REG_W-1:0] lane_t;
    typedef lane_t [DEF_VEC_N-1:0] vec_t;
    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;
endpackage

// File: rtl/vec_lane_gate.sv
// vec_lane_gate: forces every lane of one vector operand to zero where its lane-mask bit is clear.
module vec_lane_gate
    import vec_pipe_pkg::*;
#(
    parameter int REG_W = DEF_REG_W,
    parameter int VEC_N = DEF_VEC_N
) (
    input  logic [VEC_N*REG_W-1:0] vec_i,
    input  logic [VEC_N-1:0]       mask,
    output logic [VEC_N*REG_W-1:0] vec_o
);
    for (genvar l = 0; l < VEC_N; l++) begin : g_lane
        assign vec_o[l*REG_W +: REG_W] = vec_i[l*REG_W +: REG_W] & {REG_W{mask[l]}};
    end
endmodule

// File: rtl/vec_skid_pipe.sv
// vec_skid_pipe: valid/ready stage register with a 2-entry skid buffer, flush and lane zero-masking.
// Define VEC_PIPE_PERF_EN to build the saturating stall/bubble counters; otherwise they read 0.
module vec_skid_pipe
    import vec_pipe_pkg::*;
#(
    parameter int CTRL_W  = 33,
    parameter int REG_W   = 16,
    parameter int VEC_N   = 4,
    parameter int NUM_VEC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [NUM_VEC*VEC_N*REG_W-1:0] in_vec,
    input  logic [VEC_N-1:0]             in_lane_mask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [NUM_VEC*VEC_N*REG_W-1:0] out_vec,
    output logic [VEC_N-1:0]             out_lane_mask,
    output logic [OCC_W-1:0]             occupancy,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             bubble_cnt
);
    localparam int OPW = VEC_N*REG_W;
    localparam int VW  = NUM_VEC*OPW;
    localparam int EW  = CTRL_W + VW + VEC_N;

    skid_state_e state_q, state_d;
    logic [EW-1:0] main_q, main_d, skid_q, skid_d, cap;
    logic [VW-1:0] gated;
    logic in_ready_q, in_ready_d, in_fire, out_fire;

    for (genvar v = 0; v < NUM_VEC; v++) begin : g_gate
        vec_lane_gate #(.REG_W(REG_W), .VEC_N(VEC_N)) u_gate (
            .vec_i(in_vec[v*OPW +: OPW]),
            .mask (in_lane_mask),
            .vec_o(gated[v*OPW +: OPW])
        );
    end

    assign cap      = {in_ctrl, gated, in_lane_mask};
    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (in_fire) begin
                main_d  = cap;
                state_d = ONE;
            end
            ONE: if (in_fire && out_fire) begin
                main_d = cap;
            end else if (in_fire) begin
                skid_d  = cap;
                state_d = FULL;
            end else if (out_fire) begin
                state_d = EMPTY;
            end
            FULL: if (out_fire) begin
                main_d  = skid_q;
                state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops everything; data regs keep their contents so nothing toggles.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign {out_ctrl, out_vec, out_lane_mask} = main_q;

`ifdef VEC_PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = (out_valid && !out_ready && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        bubble_cnt_d = (!out_valid && out_ready && !(&bubble_cnt_q)) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif
endmodule
